vend_dispense_ctrl: RTL

//   Downstream stage of the vending FSM. Consumes its per-cycle out/change result and drives physical actuators:

---
 rtl/vend_pkg.sv | 43 ++++
 rtl/vend_event_fifo.sv | 74 +++++++
 rtl/vend_dispense_ctrl.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/vend_pkg.sv
// ---------------------------------------------------------------------------
// vend_pkg
//   Shared types and constants for the vending dispense controller slice.
//   - state_t      : dispense FSM states
//   - CHG_*        : change codes as produced by the upstream vending FSM
//   - PRICE_COINS  : product price expressed in 5 rs coins (refund amount)
//   - event_t      : one queued dispense request {vend, change}
//   - chg_coins()  : converts a change code into a number of 5 rs coins
// ---------------------------------------------------------------------------
package vend_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        VEND     = 2'd1,
        COIN_ON  = 2'd2,
        COIN_GAP = 2'd3
    } state_t;

    localparam logic [1:0] CHG_NONE = 2'b00;
    localparam logic [1:0] CHG_5    = 2'b01;
    localparam logic [1:0] CHG_10   = 2'b10;
    localparam logic [1:0] CHG_15   = 2'b11;

    localparam logic [2:0] PRICE_COINS = 3'd3;

    typedef struct packed {
        logic       vend;
        logic [1:0] change;
    } event_t;

    // Number of 5 rs coins owed for a change code.
    function automatic logic [2:0] chg_coins(input logic [1:0] code);
        logic [2:0] n;
        case (code)
            CHG_5:   n = 3'd1;
            CHG_10:  n = 3'd2;
            CHG_15:  n = 3'd3;
            default: n = 3'd0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/vend_event_fifo.sv
// ---------------------------------------------------------------------------
// vend_event_fifo
//   Small synchronous FIFO holding pending dispense events.
//   A push while full is accepted only when a pop happens on the same edge.
// Ports:
//   clk    in   clock, rising edge
//   rst    in   synchronous active-high reset (empties the queue)
//   push   in   write wdata this edge
//   pop    in   discard head entry this edge
//   wdata  in   event to enqueue
//   rdata  out  head entry (valid when !empty)
//   full   out  DEPTH entries held
//   empty  out  no entries held
// ---------------------------------------------------------------------------
module vend_event_fifo
    import vend_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   push,
    input  logic   pop,
    input  event_t wdata,
    output event_t rdata,
    output logic   full,
    output logic   empty
);

    localparam int AW = $clog2(DEPTH);

    event_t        mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    // A pop frees a slot on the same edge, so a full queue can still take a push.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign empty = (count == '0);
    assign full  = (count == (AW+1)'(DEPTH));
    assign rdata = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/vend_dispense_ctrl.sv
// ---------------------------------------------------------------------------
// vend_dispense_ctrl
//   Actuator stage behind the vending FSM. Queues {out, change} events, then
//   per event fires one product solenoid pulse and one hopper pulse per 5 rs
//   coin. A vend with no stock left refunds the price as extra coins.
// Optional feature (macro DISPENSE_STATS_EN): saturating 16-bit counters of
//   solenoid pulses (vend_total) and hopper pulses (coin_total) since reset.
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset
//   out        in   vend request (1 = dispense one product)
//   change     in   change code 00 none, 01 5 rs, 10 10 rs, 11 15 rs
//   solenoid   out  product release solenoid
//   hopper     out  coin hopper eject, one pulse per coin
//   busy       out  FSM active or events queued
//   sold_out   out  stock is zero
//   overflow   out  sticky, an event was dropped on a full queue
//   stock      out  remaining products
//   vend_total out  (DISPENSE_STATS_EN only) solenoid pulse count
//   coin_total out  (DISPENSE_STATS_EN only) hopper pulse count
// ---------------------------------------------------------------------------
module vend_dispense_ctrl
    import vend_pkg::*;
#(
    parameter int PULSE_W    = 4,
    parameter int GAP_W      = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int STOCK_W    = 4,
    parameter int STOCK_INIT = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               out,
    input  logic [1:0]         change,
    output logic               solenoid,
    output logic               hopper,
    output logic               busy,
    output logic               sold_out,
    output logic               overflow,
    output logic [STOCK_W-1:0] stock
`ifdef DISPENSE_STATS_EN
    ,
    output logic [15:0]        vend_total,
    output logic [15:0]        coin_total
`endif
);

    localparam int TMR_MAX = (PULSE_W > GAP_W) ? PULSE_W : GAP_W;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    localparam logic [TMR_W-1:0] PULSE_LAST = TMR_W'(PULSE_W - 1);
    localparam logic [TMR_W-1:0] GAP_LAST   = TMR_W'(GAP_W - 1);

    state_t             state;
    state_t             state_nx;
    logic [TMR_W-1:0]   timer;
    logic [TMR_W-1:0]   timer_nx;
    logic [2:0]         coins;
    logic [2:0]         coins_nx;
    logic [STOCK_W-1:0] stock_nx;

    logic               push;
    logic               pop;
    logic               fifo_full;
    logic               fifo_empty;
    event_t             ev_in;
    event_t             head;

    // Idle cycles (no vend, no change) are not events and never enter the queue.
    assign push          = out || (change != CHG_NONE);
    assign ev_in.vend    = out;
    assign ev_in.change  = change;

    vend_event_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (ev_in),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Next-state logic. The timer counts cycles spent in the current state and
    // restarts at zero on every transition; IDLE pops one event per visit, so
    // consecutive events are separated by exactly one IDLE cycle.
    always_comb begin
        state_nx = state;
        timer_nx = timer + TMR_W'(1);
        coins_nx = coins;
        stock_nx = stock;
        pop      = 1'b0;
        case (state)
            IDLE: begin
                timer_nx = '0;
                if (!fifo_empty) begin
                    pop      = 1'b1;
                    coins_nx = chg_coins(head.change);
                    if (head.vend && (stock != '0)) begin
                        stock_nx = stock - STOCK_W'(1);
                        state_nx = VEND;
                    end else begin
                        // Sold out: no product, give the price back as coins.
                        if (head.vend) begin
                            coins_nx = coins_nx + PRICE_COINS;
                        end
                        state_nx = (coins_nx != 3'd0) ? COIN_ON : IDLE;
                    end
                end
            end
            VEND: begin
                if (timer == PULSE_LAST) begin
                    timer_nx = '0;
                    state_nx = (coins != 3'd0) ? COIN_ON : IDLE;
                end
            end
            COIN_ON: begin
                if (timer == PULSE_LAST) begin
                    timer_nx = '0;
                    coins_nx = coins - 3'd1;
                    state_nx = (coins_nx != 3'd0) ? COIN_GAP : IDLE;
                end
            end
            COIN_GAP: begin
                if (timer == GAP_LAST) begin
                    timer_nx = '0;
                    state_nx = COIN_ON;
                end
            end
            default: begin
                timer_nx = '0;
                state_nx = IDLE;
            end
        endcase
    end

    // State and output registers. Actuators are registered copies of the
    // state, so each pulse trails its state by one cycle and the two can
    // never be high together because the FSM holds only one state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            timer    <= '0;
            coins    <= 3'd0;
            stock    <= STOCK_W'(STOCK_INIT);
            sold_out <= (STOCK_INIT == 0);
            solenoid <= 1'b0;
            hopper   <= 1'b0;
            busy     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            state    <= state_nx;
            timer    <= timer_nx;
            coins    <= coins_nx;
            stock    <= stock_nx;
            sold_out <= (stock_nx == '0);
            solenoid <= (state == VEND);
            hopper   <= (state == COIN_ON);
            busy     <= (state != IDLE) || !fifo_empty;
            overflow <= overflow || (push && fifo_full && !pop);
        end
    end

`ifdef DISPENSE_STATS_EN
    // Count a pulse on the edge where its actuator output rises.
    always_ff @(posedge clk) begin
        if (rst) begin
            vend_total <= 16'd0;
            coin_total <= 16'd0;
        end else begin
            if ((state == VEND) && !solenoid && (vend_total != 16'hFFFF)) begin
                vend_total <= vend_total + 16'd1;
            end
            if ((state == COIN_ON) && !hopper && (coin_total != 16'hFFFF)) begin
                coin_total <= coin_total + 16'd1;
            end
        end
    end
`endif

endmodule
